// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search driver for an external magnitude comparator.
// Optional one-hot flag checking via `define SAR_SEARCH_FLAG_CHECK_EN.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    input  logic             equal,
    input  logic             lower,
    input  logic             greater,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_d;
    logic [WIDTH-1:0] lo, lo_d;
    logic [WIDTH-1:0] hi, hi_d;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             bad, hit, below, above;

`ifdef SAR_SEARCH_FLAG_CHECK_EN
    logic             error_q, error_d;

    // Anything but exactly one flag is a protocol violation.
    assign bad   = !$onehot({equal, lower, greater});
    assign hit   = !bad && equal;
    assign below = !bad && lower;
    assign above = !bad && greater;
    assign error = error_q;
`else
    // Priority decode; an all-zero vector falls through to "greater".
    assign bad   = 1'b0;
    assign hit   = equal;
    assign below = !equal && lower;
    assign above = !equal && !lower;
    assign error = 1'b0;
`endif

    // Midpoint in WIDTH+1 bits so hi-lo and the sum cannot wrap.
    assign mid = WIDTH'({1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1));

    assign busy   = (state == SEARCH);
    assign done   = (state == DONE);
    assign probe  = busy ? mid : '0;
    assign found  = found_q;
    assign result = result_q;

    // Next-state and next-value logic for the search registers.
    always_comb begin
        state_d  = state;
        lo_d     = lo;
        hi_d     = hi;
        found_d  = found_q;
        result_d = result_q;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
        error_d  = error_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    lo_d     = lo_bound;
                    hi_d     = hi_bound;
                    found_d  = 1'b0;
                    result_d = '0;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
                    error_d  = 1'b0;
`endif
                    state_d  = (lo_bound > hi_bound) ? DONE : SEARCH;
                end else if (state == DONE) begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                unique case (1'b1)
                    bad: begin
                        found_d  = 1'b0;
                        result_d = '0;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
                        error_d  = 1'b1;
`endif
                        state_d  = DONE;
                    end
                    hit: begin
                        result_d = mid;
                        found_d  = 1'b1;
                        state_d  = DONE;
                    end
                    below: begin
                        if (mid == lo) state_d = DONE;
                        else           hi_d    = mid - ONE;
                    end
                    above: begin
                        if (mid == hi) state_d = DONE;
                        else           lo_d    = mid + ONE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // State and search registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            lo       <= lo_d;
            hi       <= hi_d;
            found_q  <= found_d;
            result_q <= result_d;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
            error_q  <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboard bench for sar_search_ctrl.
// Comparator modelled from a hidden target; expectations from a plain binary search.
module tb_sar_search_ctrl;

    localparam int W = 4;

    typedef struct {
        int found;
        int result;
        int error;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] lo_bound = '0;
    logic [W-1:0] hi_bound = '0;
    logic         equal, lower, greater;
    logic [W-1:0] probe;
    logic         busy, done, found, error;
    logic [W-1:0] result;

    logic [W-1:0] target = '0;
    logic         inject = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   pq[$];
    exp_t sb[$];

    bit   have_last = 0;
    exp_t last;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .lo_bound(lo_bound),
        .hi_bound(hi_bound),
        .equal   (equal),
        .lower   (lower),
        .greater (greater),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .result  (result),
        .error   (error)
    );

    always #5 clk = ~clk;

    // Combinational comparator: target on a, probe on b.
    always_comb begin
        if (inject) begin
            equal   = 1'b1;
            lower   = 1'b1;
            greater = 1'b0;
        end else begin
            equal   = (target == probe);
            lower   = (target < probe);
            greater = (target > probe);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: textbook binary search over integers.
    task automatic predict(input int l, input int h, input int t,
                           input bit inj, output int np);
        exp_t e;
        int   m;
        e  = '{0, 0, 0};
        np = 0;
        while (l <= h) begin
            m = (l + h) / 2;
            pq.push_back(m);
            np++;
            if (inj) begin
`ifdef SAR_SEARCH_FLAG_CHECK_EN
                e.error = 1;
`else
                e.found  = 1;
                e.result = m;
`endif
                break;
            end
            if (t == m) begin
                e.found  = 1;
                e.result = m;
                break;
            end else if (t < m) begin
                h = m - 1;
            end else begin
                l = m + 1;
            end
        end
        sb.push_back(e);
    endtask

    // Issue one search right after a falling edge and wait for done.
    task automatic run_search(input int l, input int h, input int t,
                              input bit inj);
        int np;
        int cyc;
        predict(l, h, t, inj, np);
        lo_bound = W'(l);
        hi_bound = W'(h);
        target   = W'(t);
        inject   = inj;
        start    = 1'b1;
        cyc      = 0;
        while (1) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            cyc++;
            if (done) break;
            if (cyc >= 40) begin
                chk("done_timeout", cyc, np + 1);
                break;
            end
        end
        if (done) chk("done_latency", cyc, np + 1);
        inject = 1'b0;
    endtask

    // Monitor: pops expected probes and outcomes as the DUT shows them.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            have_last = 0;
        end else begin
            if (busy) begin
                if (pq.size() == 0) begin
                    chk("unexpected_probe", int'(probe), -1);
                end else begin
                    chk("probe", int'(probe), pq.pop_front());
                end
                chk("found_clr", int'(found), 0);
                chk("result_clr", int'(result), 0);
            end else begin
                chk("probe_idle", int'(probe), 0);
            end
            if (done) begin
                chk("done_busy_excl", int'(busy), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("found", int'(found), e.found);
                    chk("result", int'(result), e.result);
                    chk("error", int'(error), e.error);
                    last      = e;
                    have_last = 1;
                end
            end else if (!busy && have_last) begin
                chk("found_hold", int'(found), last.found);
                chk("result_hold", int'(result), last.result);
                chk("error_hold", int'(error), last.error);
            end
        end
    end

    initial begin
        int l, h, t, g, tmp;
        bit inj;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_error", int'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_search(0, 15, 11, 0);
        run_search(0, 15, 15, 0);
        run_search(0, 15, 0, 0);
        run_search(3, 10, 12, 0);
        run_search(9, 4, 5, 0);
        repeat (2) @(negedge clk);
        run_search(0, 15, 3, 1);
        @(negedge clk);

        predict(0, 15, 15, 0, tmp);
        lo_bound = 4'd0;
        hi_bound = 4'd15;
        target   = 4'd15;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_probe", int'(probe), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_found", int'(found), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_error", int'(error), 0);
        pq.delete();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            l = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            if (l > h && $urandom_range(0, 3) != 0) begin
                tmp = l;
                l   = h;
                h   = tmp;
            end
            t   = $urandom_range(0, 15);
            inj = ($urandom_range(0, 9) == 0) && (l <= h);
            g   = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
            run_search(l, h, t, inj);
        end

        repeat (3) @(negedge clk);
        chk("probe_queue_empty", pq.size(), 0);
        chk("sb_queue_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Binary-search controller that drives the probe operand of an external magnitude comparator and consumes its equal/lower/greater flags to locate a hidden target value. It is the initiating end of the comparator interface. The comparator is combinational, with target on `a` and this block's `probe` on `b`. The block sits beside the comparator in the datapath and reports the located value, or a not-found outcome, through a done strobe.

## Interface
- `WIDTH`, default 4: width of probe, bounds and result.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begins a search; sampled only in IDLE or DONE.
- `lo_bound` input WIDTH: inclusive lower search bound, sampled with `start`.
- `hi_bound` input WIDTH: inclusive upper search bound, sampled with `start`.
- `equal` input 1: comparator flag, target == probe.
- `lower` input 1: comparator flag, target < probe.
- `greater` input 1: comparator flag, target > probe.
- `probe` output WIDTH: value presented to the comparator `b` input.
- `busy` output 1: high in SEARCH.
- `done` output 1: one-cycle strobe in DONE.
- `found` output 1: last search located the target; valid from `done` until the next `start`.
- `result` output WIDTH: located value when `found`=1, else 0.
- `error` output 1: flag protocol violation on the last search (see Configuration).

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE → SEARCH on `start`=1:
  - If `lo_bound` > `hi_bound`, go directly to DONE with `found`=0.
  - Otherwise load `lo`/`hi` registers and clear `found`, `result` and `error`.
- In SEARCH, `probe` = `lo` + ((`hi` − `lo`) >> 1). Compute this in WIDTH+1 bits; `probe` never overflows.
- Flags are sampled at each SEARCH clock edge:
  - `equal`: `result` ← `probe`, `found` ← 1, go to DONE.
  - `lower`: if `probe` == `lo`, go to DONE with `found`=0; else `hi` ← `probe` − 1.
  - `greater`: if `probe` == `hi`, go to DONE with `found`=0; else `lo` ← `probe` + 1.
- These guards forbid underflow below 0 and wrap above 2^WIDTH−1.
- DONE → SEARCH if `start`=1 (new bounds sampled); otherwise DONE → IDLE.
- `start` is ignored while in SEARCH.
- Reset mid-search: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values: `probe`=0, `busy`=0, `done`=0, `found`=0, `result`=0, `error`=0; state IDLE.
- `start` is sampled at edge 0. The first probe is valid after edge 0, and `busy`=1 from then on.
- One probe per cycle. Flags must settle combinationally within the same cycle as their probe.
- Worst case WIDTH+1 probe cycles: the last flags are sampled at edge WIDTH+1 and `done` is high in the following cycle.
- `probe` is driven to 0 outside SEARCH.
- `found`, `result` and `error` are registered and hold after DONE until the next accepted `start`.

## Configuration
- `SAR_SEARCH_FLAG_CHECK_EN` defined:
  - In SEARCH, a flag vector that is not exactly one-hot (none set, or more than one set) ends the search.
  - On that violation: go to DONE with `error`=1, `found`=0, `result`=0.
- `SAR_SEARCH_FLAG_CHECK_EN` undefined:
  - `error` is tied to 0.
  - Flags are decoded with priority `equal` > `lower` > `greater`.
  - An all-zero flag vector is treated as `greater`.

## Test plan
- WIDTH=4, bounds 0..15, target 11:
  - Required probes: 7, 11.
  - Required response: `done` one cycle after the second probe, `found`=1, `result`=11.
- WIDTH=4, bounds 0..15, extreme targets:
  - Target 15: probes 7, 11, 13, 14, 15 → `found`=1, `result`=15, no wrap.
  - Target 0: probes 7, 3, 1, 0 → `found`=1, `result`=0.
- Bounds 3..10, target 12:
  - Required probes: 6, 8, 9, 10.
  - Required response: `done` with `found`=0, `result`=0.
- Bounds 9..4 (inverted):
  - Required response: `done` on the cycle after `start`, with no SEARCH cycle, `busy` never high, `found`=0.
- Reset and back-to-back operation:
  - Assert `rst_n`=0 during the third probe: all outputs return to 0 immediately.
  - Assert `start` in the DONE cycle: a new search begins with no IDLE cycle.
- Flag violation, `equal`=1 and `lower`=1 together on the first probe:
  - With the macro defined: `error`=1, `found`=0.
  - With the macro undefined: `found`=1, `result`=7.
